// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI NOR flash responder: opcodes, FSM state
// encoding and status-register bit positions.
package spi_flash_pkg;

   localparam logic [7:0] OP_READ = 8'h03;
   localparam logic [7:0] OP_PP   = 8'h02;
   localparam logic [7:0] OP_WREN = 8'h06;
   localparam logic [7:0] OP_WRDI = 8'h04;
   localparam logic [7:0] OP_RDSR = 8'h05;
   localparam logic [7:0] OP_RDID = 8'h9F;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_RD_DATA,
      ST_WR_DATA,
      ST_STATUS,
      ST_ID,
      ST_IGNORE
   } state_t;

   // Status register is {6'b0, WEL, WIP}
   localparam int SR_WIP = 0;
   localparam int SR_WEL = 1;

endpackage

// File: rtl/spi_flash_sync.sv
// Two-flop synchronizer for the three SPI input pins plus edge detection on
// the synchronized s_clk and s_css. Edge pulses are combinational from the
// second sync stage, so a pin change is acted on at the third p_clk edge.
module spi_flash_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic s_clk,
   input  logic s_css,
   input  logic s_mosi,
   output logic sclk_rise,
   output logic sclk_fall,
   output logic css_fall,
   output logic css,
   output logic mosi
);

   // bit 0 = s_clk, bit 1 = s_css, bit 2 = s_mosi; chip select resets deselected
   localparam logic [2:0] SYNC_RST = 3'b010;

   logic [2:0] ff1_q;
   logic [2:0] ff2_q;
   logic       sclk_d_q;
   logic       css_d_q;

   // Two-stage synchronizer and one-cycle history for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ff1_q    <= SYNC_RST;
         ff2_q    <= SYNC_RST;
         sclk_d_q <= 1'b0;
         css_d_q  <= 1'b1;
      end else begin
         ff1_q    <= {s_mosi, s_css, s_clk};
         ff2_q    <= ff1_q;
         sclk_d_q <= ff2_q[0];
         css_d_q  <= ff2_q[1];
      end
   end

   assign sclk_rise = ff2_q[0] & ~sclk_d_q;
   assign sclk_fall = ~ff2_q[0] & sclk_d_q;
   assign css_fall  = ~ff2_q[1] & css_d_q;
   assign css       = ff2_q[1];
   assign mosi      = ff2_q[2];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI NOR flash responder (mode 0 slave) backed by a small internal byte array.
// Supports READ, PP, WREN, WRDI, RDSR and, when SPI_FLASH_RDID_EN is defined,
// RDID. Without SPI_FLASH_RDID_EN the RDID opcode is ignored like any unknown one.
// MEM_AW must be at least 9 so the 256-byte page sits inside the address.
module spi_flash_responder
   import spi_flash_pkg::*;
#(
   parameter int          MEM_AW      = 10,
   parameter int          PROG_CYCLES = 64,
   parameter logic [23:0] JEDEC_ID    = 24'hEF4015
) (
   input  logic p_clk,
   input  logic p_reset_n,
   input  logic s_clk,
   input  logic s_css,
   input  logic s_mosi,
   output logic s_miso
);

   localparam int CW = (PROG_CYCLES < 2) ? 1 : $clog2(PROG_CYCLES + 1);

   logic sclk_rise, sclk_fall, css_fall, css, mosi;

   spi_flash_sync u_sync (
      .clk       (p_clk),
      .rst_n     (p_reset_n),
      .s_clk     (s_clk),
      .s_css     (s_css),
      .s_mosi    (s_mosi),
      .sclk_rise (sclk_rise),
      .sclk_fall (sclk_fall),
      .css_fall  (css_fall),
      .css       (css),
      .mosi      (mosi)
   );

   state_t            state_q, state_d;
   logic [2:0]        bit_cnt_q;
   logic [1:0]        byte_cnt_q;
   logic [6:0]        shift_q;
   logic [MEM_AW-1:0] addr_q;
   logic [6:0]        tx_sr_q;
   logic [2:0]        tx_cnt_q;
   logic              miso_q;
   logic              wel_q, wip_q;
   logic [CW-1:0]     wip_cnt_q;
   logic              addr_rd_q;    // ADDR phase belongs to READ (else PP)
   logic              pp_en_q;      // WEL sampled when the PP opcode completed
   logic              pp_wrote_q;   // at least one PP byte committed
   logic              pend_wren_q;
   logic              pend_wrdi_q;

   logic [7:0]        mem [2**MEM_AW];

   logic [7:0]        rx_byte;
   logic              byte_done;
   logic              mem_we;
   logic [7:0]        status_byte;
   logic [7:0]        id_byte;
   logic [7:0]        tx_byte;

   assign rx_byte   = {shift_q, mosi};
   assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);
   assign mem_we    = (state_q == ST_WR_DATA) && !css && byte_done && pp_en_q;
   assign s_miso    = miso_q;

   // Status byte and ID byte sources for the MISO shifter
   always_comb begin
      status_byte         = 8'h00;
      status_byte[SR_WEL] = wel_q;
      status_byte[SR_WIP] = wip_q;
      id_byte             = 8'h00;
`ifdef SPI_FLASH_RDID_EN
      case (byte_cnt_q)
         2'd0:    id_byte = JEDEC_ID[23:16];
         2'd1:    id_byte = JEDEC_ID[15:8];
         2'd2:    id_byte = JEDEC_ID[7:0];
         default: id_byte = 8'h00;
      endcase
`endif
   end

`ifndef SPI_FLASH_RDID_EN
   logic unused_jedec;
   assign unused_jedec = ^JEDEC_ID;
`endif

   // Select the byte loaded at each outgoing byte boundary
   always_comb begin
      tx_byte = 8'h00;
      case (state_q)
         ST_STATUS:  tx_byte = status_byte;
         ST_RD_DATA: tx_byte = mem[addr_q];
         ST_ID:      tx_byte = id_byte;
         default:    tx_byte = 8'h00;
      endcase
   end

   // FSM state register
   always_ff @(posedge p_clk or negedge p_reset_n) begin
      if (!p_reset_n) state_q <= ST_IDLE;
      else            state_q <= state_d;
   end

   // FSM next state: deselect wins, otherwise opcode/address dispatch
   always_comb begin
      state_d = state_q;
      if (state_q != ST_IDLE && css) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (css_fall) state_d = ST_CMD;
            ST_CMD: begin
               if (byte_done) begin
                  if (wip_q && rx_byte != OP_RDSR) begin
                     state_d = ST_IGNORE;
                  end else begin
                     case (rx_byte)
                        OP_RDSR:        state_d = ST_STATUS;
                        OP_READ, OP_PP: state_d = ST_ADDR;
`ifdef SPI_FLASH_RDID_EN
                        OP_RDID:        state_d = ST_ID;
`endif
                        default:        state_d = ST_IGNORE;
                     endcase
                  end
               end
            end
            ST_ADDR: begin
               if (byte_done && byte_cnt_q == 2'd2)
                  state_d = addr_rd_q ? ST_RD_DATA : ST_WR_DATA;
            end
            default: state_d = state_q;
         endcase
      end
   end

   // Datapath: shifting, address tracking, MISO, WEL/WIP and program timer
   always_ff @(posedge p_clk or negedge p_reset_n) begin
      if (!p_reset_n) begin
         bit_cnt_q   <= '0;
         byte_cnt_q  <= '0;
         shift_q     <= '0;
         addr_q      <= '0;
         tx_sr_q     <= '0;
         tx_cnt_q    <= '0;
         miso_q      <= 1'b0;
         wel_q       <= 1'b0;
         wip_q       <= 1'b0;
         wip_cnt_q   <= '0;
         addr_rd_q   <= 1'b0;
         pp_en_q     <= 1'b0;
         pp_wrote_q  <= 1'b0;
         pend_wren_q <= 1'b0;
         pend_wrdi_q <= 1'b0;
      end else begin
         if (wip_q) begin
            wip_cnt_q <= wip_cnt_q - CW'(1);
            if (wip_cnt_q == CW'(1)) wip_q <= 1'b0;
         end
         if (state_q == ST_IDLE) begin
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            tx_cnt_q    <= '0;
            miso_q      <= 1'b0;
            pp_wrote_q  <= 1'b0;
            pend_wren_q <= 1'b0;
            pend_wrdi_q <= 1'b0;
         end else if (css) begin
            // Deselect: commit the pending effects of the finished command
            if (pend_wren_q) wel_q <= 1'b1;
            if (pend_wrdi_q) wel_q <= 1'b0;
            if (pp_wrote_q) begin
               wip_q     <= 1'b1;
               wip_cnt_q <= CW'(PROG_CYCLES);
               wel_q     <= 1'b0;
            end
            miso_q      <= 1'b0;
            pp_wrote_q  <= 1'b0;
            pend_wren_q <= 1'b0;
            pend_wrdi_q <= 1'b0;
         end else begin
            case (state_q)
               ST_CMD: begin
                  miso_q <= 1'b0;
                  if (sclk_rise) begin
                     shift_q   <= rx_byte[6:0];
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                     if (bit_cnt_q == 3'd7) begin
                        byte_cnt_q  <= '0;
                        tx_cnt_q    <= '0;
                        addr_rd_q   <= (rx_byte == OP_READ);
                        pp_en_q     <= wel_q;
                        pend_wren_q <= !wip_q && (rx_byte == OP_WREN);
                        pend_wrdi_q <= !wip_q && (rx_byte == OP_WRDI);
                     end
                  end
               end
               ST_ADDR: begin
                  miso_q <= 1'b0;
                  if (sclk_rise) begin
                     // Only the low MEM_AW bits of the 24-bit address survive
                     addr_q    <= {addr_q[MEM_AW-2:0], mosi};
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                     if (bit_cnt_q == 3'd7) byte_cnt_q <= byte_cnt_q + 2'd1;
                  end
               end
               ST_WR_DATA: begin
                  miso_q <= 1'b0;
                  if (sclk_rise) begin
                     shift_q   <= rx_byte[6:0];
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                     if (bit_cnt_q == 3'd7) begin
                        // Page program wraps inside the 256-byte page
                        addr_q <= {addr_q[MEM_AW-1:8], addr_q[7:0] + 8'd1};
                        if (pp_en_q) pp_wrote_q <= 1'b1;
                     end
                  end
               end
               ST_RD_DATA, ST_STATUS, ST_ID: begin
                  if (sclk_fall) begin
                     tx_cnt_q <= tx_cnt_q + 3'd1;
                     if (tx_cnt_q == 3'd0) begin
                        miso_q  <= tx_byte[7];
                        tx_sr_q <= tx_byte[6:0];
                        if (state_q == ST_RD_DATA) addr_q <= addr_q + MEM_AW'(1);
                        if (state_q == ST_ID && byte_cnt_q != 2'd3)
                           byte_cnt_q <= byte_cnt_q + 2'd1;
                     end else begin
                        miso_q  <= tx_sr_q[6];
                        tx_sr_q <= {tx_sr_q[5:0], 1'b0};
                     end
                  end
               end
               default: miso_q <= 1'b0;
            endcase
         end
      end
   end

   // Array write port; contents are intentionally not reset
   always_ff @(posedge p_clk) begin
      if (mem_we) mem[addr_q] <= rx_byte;
   end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Self-checking bench for spi_flash_responder. A behavioural model (byte
// array with known flags, WEL flag, WIP deadline in p_clk cycles) predicts
// every MISO byte. Honours SPI_FLASH_RDID_EN for the RDID expectations.
module tb_spi_flash_responder;

   localparam int PROG = 400;   // long program time so WIP is observable by polling
   localparam int H    = 5;     // p_clk cycles per s_clk half period
   localparam int MSZ  = 1024;
   localparam int MARG = 20;    // cycles around the WIP deadline left unchecked

   localparam logic [7:0] C_READ = 8'h03, C_PP = 8'h02, C_WREN = 8'h06;
   localparam logic [7:0] C_WRDI = 8'h04, C_RDSR = 8'h05, C_RDID = 8'h9F;

   // ---------------- clock / reset ----------------
   logic p_clk = 1'b0, p_reset_n = 1'b0;
   logic s_clk = 1'b0, s_css = 1'b1, s_mosi = 1'b0;
   logic s_miso;
   int   cyc = 0;

   always #5 p_clk = ~p_clk;
   always @(posedge p_clk) cyc <= cyc + 1;

   spi_flash_responder #(.MEM_AW(10), .PROG_CYCLES(PROG), .JEDEC_ID(24'hEF4015)) dut (
      .p_clk     (p_clk),
      .p_reset_n (p_reset_n),
      .s_clk     (s_clk),
      .s_css     (s_css),
      .s_mosi    (s_mosi),
      .s_miso    (s_miso)
   );

   // ---------------- scoreboard / model ----------------
   int         n_checks = 0, n_errors = 0;
   logic [7:0] mdl_mem [MSZ];
   bit         mdl_known [MSZ];
   bit         mdl_wel = 1'b0;
   int         wip_end = -100000;
   int         cs_rise_cyc = 0;
   logic [7:0] wr_buf [8];

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %02h expected %02h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic wait_clk(input int n);
      repeat (n) @(negedge p_clk);
   endtask

   task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
      rx = '0;
      for (int i = 7; i > 7 - n; i--) begin
         s_mosi = tx[i];
         wait_clk(H);
         rx[i] = s_miso;
         s_clk = 1'b1;
         wait_clk(H);
         s_clk = 1'b0;
      end
   endtask

   task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
      spi_bits(tx, 8, rx);
   endtask

   task automatic cs_low();
      s_css = 1'b0;
      wait_clk(H);
   endtask

   task automatic cs_high();
      wait_clk(H);
      s_css = 1'b1;
      cs_rise_cyc = cyc;
      wait_clk(8);
   endtask

   task automatic send_addr(input int addr);
      logic [23:0] a;
      logic [7:0]  d;
      a = addr[23:0];
      spi_byte(a[23:16], d);
      spi_byte(a[15:8], d);
      spi_byte(a[7:0], d);
   endtask

   task automatic simple_cmd(input logic [7:0] op);
      logic [7:0] d;
      cs_low();
      spi_byte(op, d);
      if (cyc >= wip_end + MARG) begin
         if (op == C_WREN) mdl_wel = 1'b1;
         if (op == C_WRDI) mdl_wel = 1'b0;
      end
      cs_high();
   endtask

   task automatic rdsr_check(input string tag, output logic [7:0] st);
      logic [7:0] d;
      int t;
      cs_low();
      spi_byte(C_RDSR, d);
      t = cyc;
      spi_byte(8'h00, st);
      cs_high();
      if (t < wip_end - MARG)      check(tag, st, {6'b0, mdl_wel, 1'b1});
      else if (t > wip_end + MARG) check(tag, st, {6'b0, mdl_wel, 1'b0});
   endtask

   task automatic wait_wip(input string tag);
      logic [7:0] st;
      st = 8'hFF;
      for (int k = 0; k < 10; k++) begin
         rdsr_check(tag, st);
         if (st[0] == 1'b0) break;
      end
      check({tag, "_wip_done"}, {7'b0, st[0]}, 8'h00);
   endtask

   task automatic page_prog(input int addr, input int n, input int part_bits);
      logic [7:0] d;
      bit en;
      int idx;
      cs_low();
      spi_byte(C_PP, d);
      en = mdl_wel && (cyc >= wip_end + MARG);
      send_addr(addr);
      for (int i = 0; i < n; i++) spi_byte(wr_buf[i], d);
      if (part_bits > 0) spi_bits(8'hC3, part_bits, d);
      cs_high();
      if (en && n > 0) begin
         for (int i = 0; i < n; i++) begin
            idx = ((addr & ~255) | ((addr + i) & 255)) & (MSZ - 1);
            mdl_mem[idx]   = wr_buf[i];
            mdl_known[idx] = 1'b1;
         end
         mdl_wel = 1'b0;
         wip_end = cs_rise_cyc + 3 + PROG;
      end
   endtask

   task automatic read_check(input string tag, input int addr, input int n);
      logic [7:0] d;
      int t0, idx;
      cs_low();
      spi_byte(C_READ, d);
      t0 = cyc;
      send_addr(addr);
      for (int i = 0; i < n; i++) begin
         spi_byte(8'h00, d);
         idx = (addr + i) & (MSZ - 1);
         if (t0 < wip_end - MARG)                         check(tag, d, 8'h00);
         else if (t0 > wip_end + MARG && mdl_known[idx])  check(tag, d, mdl_mem[idx]);
      end
      cs_high();
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #900000;
      n_checks++;
      n_errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [7:0] d, st;
      logic [7:0] id_exp [4];
      int base, n, part;

      for (int i = 0; i < MSZ; i++) mdl_known[i] = 1'b0;

      wait_clk(4);
      check("reset_miso", {7'b0, s_miso}, 8'h00);
      p_reset_n = 1'b1;
      wait_clk(4);
      rdsr_check("reset_sr", st);

      // WREN then WRDI, and WREN alone
      simple_cmd(C_WREN);
      rdsr_check("wren_sr", st);
      simple_cmd(C_WRDI);
      rdsr_check("wrdi_sr", st);
      simple_cmd(C_WREN);

      // Reset in the middle of a READ with CS held low
      cs_low();
      spi_byte(C_READ, d);
      send_addr(0);
      spi_byte(8'h00, d);
      spi_bits(8'h00, 3, d);
      p_reset_n = 1'b0;
      wait_clk(2);
      check("midread_rst_miso", {7'b0, s_miso}, 8'h00);
      wait_clk(3);
      p_reset_n = 1'b1;
      wait_clk(3);
      cs_high();
      mdl_wel = 1'b0;
      rdsr_check("post_rst_sr", st);

      // Truncated WREN (5 bits) must not set WEL
      cs_low();
      spi_bits(C_WREN, 5, d);
      cs_high();
      rdsr_check("short_wren_sr", st);

      // WREN + PP 0x10, then WREN and READ during WIP
      simple_cmd(C_WREN);
      wr_buf[0] = 8'hA5;
      wr_buf[1] = 8'h5A;
      page_prog(32'h10, 2, 0);
      simple_cmd(C_WREN);
      rdsr_check("wip_sr", st);
      read_check("wip_read", 32'h10, 2);
      wait_wip("pp10_sr");
      read_check("pp10_read", 32'h10, 2);

      // Program 0x20 with 0x77, then PP without WREN must not change it
      simple_cmd(C_WREN);
      wr_buf[0] = 8'h77;
      page_prog(32'h20, 1, 0);
      wait_wip("pp20_sr");
      wr_buf[0] = 8'h11;
      page_prog(32'h20, 1, 0);
      rdsr_check("nowren_sr", st);
      read_check("nowren_read", 32'h20, 1);

      // Page wrap: 4 bytes at 0xFE
      simple_cmd(C_WREN);
      for (int i = 0; i < 4; i++) wr_buf[i] = 8'(i + 1);
      page_prog(32'hFE, 4, 0);
      wait_wip("wrap_sr");
      read_check("wrap_read_lo", 32'h000, 2);
      read_check("wrap_read_hi", 32'hFE, 2);

      // Whole-array wrap on READ
      simple_cmd(C_WREN);
      wr_buf[0] = 8'h3C;
      page_prog(32'h3FF, 1, 0);
      wait_wip("top_sr");
      read_check("array_wrap_read", 32'h3FF, 2);

      // CS rise mid-byte during PP keeps the complete bytes only
      simple_cmd(C_WREN);
      wr_buf[0] = 8'hB1;
      wr_buf[1] = 8'hB2;
      page_prog(32'h40, 2, 4);
      wait_wip("abort_sr");
      read_check("abort_read", 32'h40, 3);

      // RDID
`ifdef SPI_FLASH_RDID_EN
      id_exp[0] = 8'hEF; id_exp[1] = 8'h40; id_exp[2] = 8'h15; id_exp[3] = 8'h00;
`else
      for (int i = 0; i < 4; i++) id_exp[i] = 8'h00;
`endif
      cs_low();
      spi_byte(C_RDID, d);
      for (int i = 0; i < 4; i++) begin
         spi_byte(8'h00, d);
         check($sformatf("rdid_%0d", i), d, id_exp[i]);
      end
      cs_high();

      // Randomized program/read traffic against the model
      for (int it = 0; it < 8; it++) begin
         base = int'($urandom_range(0, 32'hFFFFFF));
         n    = int'($urandom_range(1, 5));
         for (int i = 0; i < n; i++) wr_buf[i] = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 3) != 0) simple_cmd(C_WREN);
         part = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
         page_prog(base, n, part);
         wait_wip("rnd_sr");
         read_check("rnd_read", base, n + 1);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
